// File: rtl/ecc_secded_encoder_pipe_if.sv
// ecc_secded_encoder_pipe_if
// Bundles the write-side stream, the encoded output stream, the word
// counter and the fault-injection controls of the SECDED encoder pipe.
// The "slave" modport is the encoder's view; "master" is the view of the
// logic around it (write mux upstream, SRAM bank downstream).
interface ecc_secded_encoder_pipe_if #(
   parameter int DATA_W = 32,
   parameter int CODE_W = 6,
   parameter int CNT_W  = 16
);
   logic [DATA_W-1:0] in_data;
   logic              in_vld;
   logic              in_rdy;
   logic [DATA_W-1:0] out_data;
   logic [CODE_W:0]   out_code;
   logic              out_vld;
   logic              out_rdy;
   logic [CNT_W-1:0]  enc_cnt;
   logic              inj_req;
   logic [7:0]        inj_idx;
   logic              inj_armed;

   modport master (
      output in_data, in_vld, out_rdy, inj_req, inj_idx,
      input  in_rdy, out_data, out_code, out_vld, enc_cnt, inj_armed
   );

   modport slave (
      input  in_data, in_vld, out_rdy, inj_req, inj_idx,
      output in_rdy, out_data, out_code, out_vld, enc_cnt, inj_armed
   );
endinterface

// File: rtl/ecc_secded_encoder_pipe.sv
// ecc_secded_encoder_pipe
// SECDED encoder (Hamming check bits plus overall even parity) with a single
// registered output stage under valid/ready flow control and a saturating
// count of accepted words. Check bit i occupies codeword position 2^i; data
// bits fill the remaining positions in ascending order, in_data[0] first.
// out_code = {overall_parity, check[CODE_W-1:0]}.
// Optional build macro ECC_ERR_INJ_EN adds single-bit fault injection into
// {code,data} of the next accepted word, for exercising the decoder.
// CODE_W must satisfy 2^CODE_W >= DATA_W+CODE_W+1, and the interface
// instance must carry the same DATA_W/CODE_W/CNT_W as this module.
module ecc_secded_encoder_pipe #(
   parameter int DATA_W = 32,
   parameter int CODE_W = 6,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   ecc_secded_encoder_pipe_if.slave bus
);

   localparam int N_POS  = DATA_W + CODE_W;   // Hamming positions 1..N_POS
   localparam int WORD_W = N_POS + 1;         // {parity, check, data}

   // Codeword position of data bit j: the j-th non-power-of-two position.
   function automatic int data_pos(input int j);
      int k;
      int pos;
      k   = 0;
      pos = 0;
      for (int p = 1; p <= N_POS; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (k == j) pos = p;
            k++;
         end
      end
      return pos;
   endfunction

   logic [CODE_W-1:0] w_check;
   logic              w_parity;
   logic [WORD_W-1:0] w_word_clean;
   logic [WORD_W-1:0] w_flip;
   logic [WORD_W-1:0] w_word;
   logic              w_accept;

   logic              r_out_vld;
   logic [DATA_W-1:0] r_out_data;
   logic [CODE_W:0]   r_out_code;
   logic [CNT_W-1:0]  r_enc_cnt;

   // Check bit i covers every data bit whose codeword position has bit i set.
   always_comb begin
      // NOTE: defaulting every combinational output before the loops keeps
      // the block free of latches regardless of which branches fire.
      w_check = '0;
      for (int j = 0; j < DATA_W; j++) begin
         for (int i = 0; i < CODE_W; i++) begin
            if (((data_pos(j) >> i) & 1) != 0) begin
               w_check[i] = w_check[i] ^ bus.in_data[j];
            end
         end
      end
   end

   assign w_parity     = (^bus.in_data) ^ (^w_check);
   assign w_word_clean = {w_parity, w_check, bus.in_data};
   assign w_word       = w_word_clean ^ w_flip;

   // Upstream may load whenever the output register is empty or draining now.
   assign bus.in_rdy = !r_out_vld || bus.out_rdy;
   assign w_accept   = bus.in_vld && bus.in_rdy;

`ifdef ECC_ERR_INJ_EN
   logic       r_inj_armed;
   logic [7:0] r_inj_idx;

   // An out-of-range index shifts the single one out of the word, so the
   // armed word goes out clean while the arm is still consumed.
   assign w_flip = r_inj_armed ? (WORD_W'(1) << r_inj_idx) : '0;

   // Arm on request (a new request overwrites the index); disarm on the
   // accept that consumes it. The request edge itself never injects because
   // the flip uses the armed state from before that edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_inj_armed <= 1'b0;
         r_inj_idx   <= '0;
      end else if (bus.inj_req) begin
         r_inj_armed <= 1'b1;
         r_inj_idx   <= bus.inj_idx;
      end else if (w_accept) begin
         r_inj_armed <= 1'b0;
      end
   end

   assign bus.inj_armed = r_inj_armed;
`else
   logic w_unused_inj;

   assign w_flip        = '0;
   assign bus.inj_armed = 1'b0;
   assign w_unused_inj  = ^{bus.inj_req, bus.inj_idx};
`endif

   // Output register: load on accept (also when draining in the same cycle),
   // otherwise drop valid once the consumer takes the word.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of block ordering.
      if (reset) begin
         r_out_vld  <= 1'b0;
         r_out_data <= '0;
         r_out_code <= '0;
      end else if (w_accept) begin
         r_out_vld                <= 1'b1;
         {r_out_code, r_out_data} <= w_word;
      end else if (bus.out_rdy) begin
         r_out_vld <= 1'b0;
      end
   end

   // Saturating count of accepted words; it holds at all-ones, never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_enc_cnt <= '0;
      end else if (w_accept && (r_enc_cnt != {CNT_W{1'b1}})) begin
         r_enc_cnt <= r_enc_cnt + 1'b1;
      end
   end

   assign bus.out_vld  = r_out_vld;
   assign bus.out_data = r_out_data;
   assign bus.out_code = r_out_code;
   assign bus.enc_cnt  = r_enc_cnt;

endmodule

// File: tb/tb_ecc_secded_encoder_pipe.sv
// tb_ecc_secded_encoder_pipe
// Self-checking bench for ecc_secded_encoder_pipe. Expected codes come from
// a syndrome-style model: the check field equals the XOR of the codeword
// positions of all set data bits, and the parity makes the whole codeword
// even. A queue scoreboard tracks words between accept and drain.
// Honours ECC_ERR_INJ_EN the same way as the design.
module tb_ecc_secded_encoder_pipe;
   localparam int DATA_W  = 32;
   localparam int CODE_W  = 6;
   localparam int CNT_W   = 4;
   localparam int WORD_W  = DATA_W + CODE_W + 1;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;

   ecc_secded_encoder_pipe_if #(.DATA_W(DATA_W), .CODE_W(CODE_W), .CNT_W(CNT_W)) bus ();

   ecc_secded_encoder_pipe #(.DATA_W(DATA_W), .CODE_W(CODE_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int                checks = 0;
   int                errors = 0;
   logic [WORD_W-1:0] q [$];
   int                n_acc = 0;
   logic              m_armed = 1'b0;
   int                m_idx = 0;
   logic              hold_valid = 1'b0;
   logic [WORD_W-1:0] hold_word;

   // Reference code: XOR of positions of set data bits gives the check field.
   function automatic logic [CODE_W:0] model_code(input logic [DATA_W-1:0] d);
      int                pos;
      int                syn;
      int                ones;
      logic [CODE_W-1:0] chk;
      pos  = 1;
      syn  = 0;
      ones = 0;
      for (int j = 0; j < DATA_W; j++) begin
         pos++;
         while ((pos & (pos - 1)) == 0) pos++;
         if (d[j]) begin
            syn  = syn ^ pos;
            ones = ones + 1;
         end
      end
      chk  = syn[CODE_W-1:0];
      ones = ones + $countones(chk);
      return {ones[0], chk};
   endfunction

   // One clock cycle, entered and left at the falling edge with inputs set.
   task automatic step();
      logic              fire_in;
      logic              fire_out;
      logic [WORD_W-1:0] got_word;
      logic [WORD_W-1:0] exp_word;
      int                exp_cnt;
      #1;
      got_word = {bus.out_code, bus.out_data};
      fire_in  = bus.in_vld && bus.in_rdy;
      fire_out = bus.out_vld && bus.out_rdy;
      checks++;
      if (bus.out_vld !== (q.size() != 0)) begin
         errors++;
         $display("FAIL out_vld: got %b expected %b", bus.out_vld, q.size() != 0);
      end
      checks++;
      if (bus.in_rdy !== (!bus.out_vld || bus.out_rdy)) begin
         errors++;
         $display("FAIL in_rdy: got %b out_vld %b out_rdy %b", bus.in_rdy, bus.out_vld, bus.out_rdy);
      end
      exp_cnt = (n_acc > CNT_MAX) ? CNT_MAX : n_acc;
      checks++;
      if (bus.enc_cnt !== CNT_W'(exp_cnt)) begin
         errors++;
         $display("FAIL enc_cnt: got %0d expected %0d", bus.enc_cnt, exp_cnt);
      end
      checks++;
      if (bus.inj_armed !== m_armed) begin
         errors++;
         $display("FAIL inj_armed: got %b expected %b", bus.inj_armed, m_armed);
      end
      if (hold_valid) begin
         checks++;
         if (got_word !== hold_word) begin
            errors++;
            $display("FAIL hold_stable: got %h expected %h", got_word, hold_word);
         end
      end
      hold_valid = bus.out_vld && !bus.out_rdy;
      hold_word  = got_word;
      if (fire_out) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got %h expected nothing", got_word);
         end else begin
            exp_word = q.pop_front();
            if (got_word !== exp_word) begin
               errors++;
               $display("FAIL output_word: got %h expected %h", got_word, exp_word);
            end
         end
      end
      if (fire_in) begin
         exp_word = {model_code(bus.in_data), bus.in_data};
         if (m_armed && m_idx < WORD_W) exp_word[m_idx] = ~exp_word[m_idx];
         q.push_back(exp_word);
         n_acc++;
      end
`ifdef ECC_ERR_INJ_EN
      if (bus.inj_req) begin
         m_armed = 1'b1;
         m_idx   = int'(bus.inj_idx);
      end else if (fire_in) begin
         m_armed = 1'b0;
      end
`endif
      @(posedge clk);
      @(negedge clk);
   endtask

   // Asserts reset between clock edges; callers check the async effect.
   task automatic apply_reset();
      #2 reset = 1'b1;
      #1;
      q.delete();
      n_acc       = 0;
      m_armed     = 1'b0;
      hold_valid  = 1'b0;
      bus.in_vld  = 1'b0;
      bus.inj_req = 1'b0;
   endtask

   task automatic release_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (bus.out_vld !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_vld: got %b expected 0", bus.out_vld);
      end
      checks++;
      if (bus.out_data !== '0) begin
         errors++;
         $display("FAIL reset_out_data: got %h expected 0", bus.out_data);
      end
      checks++;
      if (bus.out_code !== '0) begin
         errors++;
         $display("FAIL reset_out_code: got %h expected 0", bus.out_code);
      end
      checks++;
      if (bus.enc_cnt !== '0) begin
         errors++;
         $display("FAIL reset_enc_cnt: got %0d expected 0", bus.enc_cnt);
      end
      checks++;
      if (bus.inj_armed !== 1'b0) begin
         errors++;
         $display("FAIL reset_inj_armed: got %b expected 0", bus.inj_armed);
      end
      release_reset();
   endtask

   task automatic test_vectors();
      logic [DATA_W-1:0] vd [3];
      logic [CODE_W:0]   vc [3];
      vd[0] = 32'h0000_0000; vc[0] = 7'h00;
      vd[1] = 32'h0000_0001; vc[1] = 7'h43;
      vd[2] = 32'hFFFF_FFFF; vc[2] = 7'h18;
      bus.out_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_data = vd[i];
         bus.in_vld  = 1'b1;
         step();
         bus.in_vld = 1'b0;
         checks++;
         if (bus.out_vld !== 1'b1 || bus.out_data !== vd[i] || bus.out_code !== vc[i]) begin
            errors++;
            $display("FAIL vector_%0d: got vld %b data %h code %h expected vld 1 data %h code %h",
                     i, bus.out_vld, bus.out_data, bus.out_code, vd[i], vc[i]);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      release_reset();
      bus.out_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_data = $urandom;
         bus.in_vld  = 1'b1;
         step();
         checks++;
         if (bus.out_vld !== 1'b1) begin
            errors++;
            $display("FAIL b2b_vld_%0d: got %b expected 1", i, bus.out_vld);
         end
      end
      bus.in_vld = 1'b0;
      checks++;
      if (bus.enc_cnt !== CNT_W'(4)) begin
         errors++;
         $display("FAIL b2b_enc_cnt: got %0d expected 4", bus.enc_cnt);
      end
      step();
      step();
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] d_a;
      logic [DATA_W-1:0] d_b;
      d_a = $urandom;
      d_b = $urandom;
      bus.out_rdy = 1'b1;
      bus.in_data = d_a;
      bus.in_vld  = 1'b1;
      step();
      bus.out_rdy = 1'b0;
      bus.in_data = d_b;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.in_rdy !== 1'b0 || bus.out_data !== d_a) begin
            errors++;
            $display("FAIL stall_%0d: got in_rdy %b data %h expected in_rdy 0 data %h",
                     i, bus.in_rdy, bus.out_data, d_a);
         end
         @(negedge clk);
         step();
      end
      bus.out_rdy = 1'b1;
      step();
      bus.in_vld = 1'b0;
      checks++;
      if (bus.out_data !== d_b) begin
         errors++;
         $display("FAIL stall_release: got %h expected %h", bus.out_data, d_b);
      end
      step();
      step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bus.in_data = $urandom;
         bus.in_vld  = ($urandom_range(0, 3) != 0);
         bus.out_rdy = ($urandom_range(0, 2) != 0);
         bus.inj_req = !bus.in_vld && ($urandom_range(0, 15) == 0);
         bus.inj_idx = 8'($urandom_range(0, 45));
         step();
      end
      bus.in_vld  = 1'b0;
      bus.inj_req = 1'b0;
      bus.out_rdy = 1'b1;
      step();
      step();
   endtask

   task automatic test_saturation();
      apply_reset();
      release_reset();
      bus.out_rdy = 1'b1;
      bus.in_vld  = 1'b1;
      for (int i = 0; i < CNT_MAX + 5; i++) begin
         bus.in_data = $urandom;
         step();
      end
      bus.in_vld = 1'b0;
      checks++;
      if (bus.enc_cnt !== CNT_W'(CNT_MAX)) begin
         errors++;
         $display("FAIL enc_cnt_saturate: got %0d expected %0d", bus.enc_cnt, CNT_MAX);
      end
      step();
   endtask

   task automatic test_reset_mid();
      logic [DATA_W-1:0] d_new;
      bus.out_rdy = 1'b0;
      bus.in_data = $urandom;
      bus.in_vld  = 1'b1;
      step();
      step();
      apply_reset();
      checks++;
      if (bus.out_vld !== 1'b0 || bus.enc_cnt !== '0) begin
         errors++;
         $display("FAIL reset_mid: got out_vld %b enc_cnt %0d expected 0 0", bus.out_vld, bus.enc_cnt);
      end
      release_reset();
      d_new       = $urandom;
      bus.out_rdy = 1'b1;
      bus.in_data = d_new;
      bus.in_vld  = 1'b1;
      step();
      bus.in_vld = 1'b0;
      checks++;
      if (bus.out_vld !== 1'b1 || bus.out_data !== d_new) begin
         errors++;
         $display("FAIL reset_mid_first: got vld %b data %h expected vld 1 data %h",
                  bus.out_vld, bus.out_data, d_new);
      end
      step();
   endtask

   task automatic test_injection();
      logic [DATA_W-1:0] d;
      apply_reset();
      release_reset();
      bus.out_rdy = 1'b1;
      bus.inj_req = 1'b1;
      bus.inj_idx = 8'd0;
      step();
      bus.inj_req = 1'b0;
`ifdef ECC_ERR_INJ_EN
      checks++;
      if (bus.inj_armed !== 1'b1) begin
         errors++;
         $display("FAIL inj_arm: got %b expected 1", bus.inj_armed);
      end
      bus.in_data = 32'h0;
      bus.in_vld  = 1'b1;
      step();
      bus.in_vld = 1'b0;
      checks++;
      if (bus.out_data !== 32'h1 || bus.out_code !== 7'h00 || bus.inj_armed !== 1'b0) begin
         errors++;
         $display("FAIL inj_flip0: got data %h code %h armed %b expected data 1 code 0 armed 0",
                  bus.out_data, bus.out_code, bus.inj_armed);
      end
      bus.in_vld = 1'b1;
      step();
      bus.in_vld = 1'b0;
      checks++;
      if (bus.out_data !== 32'h0 || bus.out_code !== 7'h00) begin
         errors++;
         $display("FAIL inj_next_clean: got data %h code %h expected 0 0", bus.out_data, bus.out_code);
      end
      step();
      // Out-of-range index: arm consumed, word unchanged.
      d           = $urandom;
      bus.inj_req = 1'b1;
      bus.inj_idx = 8'd200;
      step();
      bus.inj_req = 1'b0;
      bus.in_data = d;
      bus.in_vld  = 1'b1;
      step();
      bus.in_vld = 1'b0;
      checks++;
      if ({bus.out_code, bus.out_data} !== {model_code(d), d} || bus.inj_armed !== 1'b0) begin
         errors++;
         $display("FAIL inj_out_of_range: got %h armed %b expected %h armed 0",
                  {bus.out_code, bus.out_data}, bus.inj_armed, {model_code(d), d});
      end
      step();
      // A word accepted on the arming edge is not injected; the next one is.
      d           = $urandom;
      bus.inj_req = 1'b1;
      bus.inj_idx = 8'd5;
      bus.in_data = d;
      bus.in_vld  = 1'b1;
      step();
      bus.inj_req = 1'b0;
      checks++;
      if (bus.out_data !== d || bus.inj_armed !== 1'b1) begin
         errors++;
         $display("FAIL inj_same_edge: got data %h armed %b expected data %h armed 1",
                  bus.out_data, bus.inj_armed, d);
      end
      step();
      bus.in_vld = 1'b0;
      checks++;
      if (bus.out_data !== (d ^ 32'h20) || bus.inj_armed !== 1'b0) begin
         errors++;
         $display("FAIL inj_after_edge: got data %h armed %b expected data %h armed 0",
                  bus.out_data, bus.inj_armed, d ^ 32'h20);
      end
      step();
`else
      checks++;
      if (bus.inj_armed !== 1'b0) begin
         errors++;
         $display("FAIL inj_disabled_arm: got %b expected 0", bus.inj_armed);
      end
      bus.in_data = 32'h0;
      bus.in_vld  = 1'b1;
      step();
      bus.in_vld = 1'b0;
      checks++;
      if (bus.out_data !== 32'h0 || bus.out_code !== 7'h00) begin
         errors++;
         $display("FAIL inj_disabled_word: got data %h code %h expected 0 0", bus.out_data, bus.out_code);
      end
      step();
`endif
   endtask

   initial begin
      reset       = 1'b0;
      bus.in_data = '0;
      bus.in_vld  = 1'b0;
      bus.out_rdy = 1'b0;
      bus.inj_req = 1'b0;
      bus.inj_idx = '0;
      @(negedge clk);
      test_reset();
      test_vectors();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_saturation();
      test_reset_mid();
      test_injection();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Bounds the whole run in case the design stalls the bench.
   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

endmodule
